// File: rtl/pi_gpio_readback_tx.sv
// Streams the image buffer back to the Raspberry Pi over the shared GPIO bus, one byte per 4-phase handshake.
// Build option: define PI_READBACK_CHECKSUM_EN to append a modulo-256 checksum byte after the image.
module pi_gpio_readback_tx #(
    parameter int HEIGHT = 20,
    parameter int WIDTH  = 30,
    parameter int DEPTH  = 3,
    parameter int ADDR_W = 11
) (
    input  logic              pi_clk,
    input  logic              rst,
    input  logic              read_req,
    input  logic              pi_ack,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        gpio_out,
    output logic              gpio_oe,
    output logic              tx_valid,
    output logic              busy,
    output logic              done
);

    localparam int TOTAL = HEIGHT * WIDTH * DEPTH;

    typedef logic [ADDR_W:0] idx_t;

`ifdef PI_READBACK_CHECKSUM_EN
    localparam idx_t CKS_SLOT  = idx_t'(TOTAL);
    localparam idx_t BYTE_LAST = CKS_SLOT;
`else
    localparam idx_t BYTE_LAST = idx_t'(TOTAL - 1);
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LATCH   = 3'd2,
        PRESENT = 3'd3,
        RELEASE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            state_q;
    idx_t              idx_q;
    idx_t              idx_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        gpio_out_q;
    logic              gpio_oe_q;
    logic              tx_valid_q;
    logic              busy_q;
    logic              done_q;

    assign idx_d = idx_q + idx_t'(1);

`ifdef PI_READBACK_CHECKSUM_EN
    logic [7:0] cks_q;
    logic [7:0] cks_d;

    assign cks_d = cks_q + mem_rdata;
`endif

    assign mem_addr = mem_addr_q;
    assign gpio_out = gpio_out_q;
    assign gpio_oe  = gpio_oe_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

    always_ff @(posedge pi_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            mem_addr_q <= '0;
            gpio_out_q <= '0;
            gpio_oe_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef PI_READBACK_CHECKSUM_EN
            cks_q      <= '0;
`endif
        end else begin
            // Dropping read_req mid-transfer abandons the frame; a restart always begins at address 0.
            if (!read_req && state_q != IDLE && state_q != DONE) begin
                state_q    <= IDLE;
                tx_valid_q <= 1'b0;
                gpio_oe_q  <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        done_q <= 1'b0;
                        if (read_req && !pi_ack) begin
                            state_q    <= FETCH;
                            idx_q      <= '0;
                            mem_addr_q <= '0;
                            busy_q     <= 1'b1;
                            gpio_oe_q  <= 1'b1;
`ifdef PI_READBACK_CHECKSUM_EN
                            cks_q      <= '0;
`endif
                        end
                    end
                    FETCH: begin
                        state_q <= LATCH;
                    end
                    LATCH: begin
`ifdef PI_READBACK_CHECKSUM_EN
                        if (idx_q == CKS_SLOT) begin
                            gpio_out_q <= cks_q;
                        end else begin
                            gpio_out_q <= mem_rdata;
                            cks_q      <= cks_d;
                        end
`else
                        gpio_out_q <= mem_rdata;
`endif
                        tx_valid_q <= 1'b1;
                        state_q    <= PRESENT;
                    end
                    PRESENT: begin
                        if (pi_ack) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (!pi_ack) begin
                            if (idx_q == BYTE_LAST) begin
                                state_q   <= DONE;
                                done_q    <= 1'b1;
                                busy_q    <= 1'b0;
                                gpio_oe_q <= 1'b0;
                            end else begin
                                state_q <= FETCH;
                                idx_q   <= idx_d;
`ifdef PI_READBACK_CHECKSUM_EN
                                // The checksum slot has no memory word; the address stays on the last image byte.
                                if (idx_d != CKS_SLOT) begin
                                    mem_addr_q <= idx_d[ADDR_W-1:0];
                                end
`else
                                mem_addr_q <= idx_d[ADDR_W-1:0];
`endif
                            end
                        end
                    end
                    DONE: begin
                        tx_valid_q <= 1'b0;
                        if (!read_req) begin
                            state_q <= IDLE;
                            done_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pi_gpio_readback_tx.sv
// Directed + randomized bench for pi_gpio_readback_tx: models the image memory and the Pi side of the handshake.
// Expected byte stream is derived from the memory contents (plus checksum when PI_READBACK_CHECKSUM_EN is defined).
module tb_pi_gpio_readback_tx;

    localparam int HEIGHT = 20;
    localparam int WIDTH  = 30;
    localparam int DEPTH  = 3;
    localparam int ADDR_W = 11;
    localparam int TOTAL  = HEIGHT * WIDTH * DEPTH;
`ifdef PI_READBACK_CHECKSUM_EN
    localparam int NB = TOTAL + 1;
`else
    localparam int NB = TOTAL;
`endif

    logic              pi_clk;
    logic              rst;
    logic              read_req;
    logic              pi_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [7:0]        gpio_out;
    logic              gpio_oe;
    logic              tx_valid;
    logic              busy;
    logic              done;

    logic [7:0] mem   [0:(1<<ADDR_W)-1];
    logic [7:0] exp_q [0:NB-1];

    int n_cmp;
    int n_err;

    pi_gpio_readback_tx #(
        .HEIGHT(HEIGHT),
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .pi_clk   (pi_clk),
        .rst      (rst),
        .read_req (read_req),
        .pi_ack   (pi_ack),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .tx_valid (tx_valid),
        .busy     (busy),
        .done     (done)
    );

    initial pi_clk = 1'b0;
    always #5 pi_clk = ~pi_clk;

    // Synchronous-read image memory: data appears one cycle after the address.
    always @(posedge pi_clk) mem_rdata <= mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic build_exp();
        for (int i = 0; i < TOTAL; i++) exp_q[i] = mem[i];
`ifdef PI_READBACK_CHECKSUM_EN
        begin
            int s;
            s = 0;
            for (int i = 0; i < TOTAL; i++) s += int'(mem[i]);
            exp_q[TOTAL] = 8'(s % 256);
        end
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 32'({mem_addr, gpio_out, gpio_oe, tx_valid, busy, done}), 32'd0);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (tx_valid !== 1'b1 && n < 20) begin
            @(negedge pi_clk);
            n++;
        end
    endtask

    // One Pi-side handshake: called right after start or after pi_ack was dropped.
    task automatic xfer(input int k, input int dly, input int hold);
        int n;
        wait_valid(n);
        chk($sformatf("latency%0d", k), 32'(n), 32'd3);
        chk($sformatf("byte%0d", k), 32'(gpio_out), 32'(exp_q[k]));
        chk($sformatf("oe_busy%0d", k), 32'({gpio_oe, busy}), 32'd3);
        for (int d = 0; d < dly; d++) begin
            @(negedge pi_clk);
            chk($sformatf("stable%0d", k), 32'({tx_valid, gpio_out}), 32'({1'b1, exp_q[k]}));
        end
        pi_ack = 1'b1;
        @(negedge pi_clk);
        chk($sformatf("vdrop%0d", k), 32'(tx_valid), 32'd0);
        for (int h = 0; h < hold; h++) @(negedge pi_clk);
        pi_ack = 1'b0;
    endtask

    task automatic chk_done(input string tag);
        @(negedge pi_clk);
        chk(tag, 32'({done, busy, gpio_oe, tx_valid}), 32'b1000);
    endtask

    initial begin
        int n;
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        read_req = 1'b0;
        pi_ack   = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'(i);
        repeat (3) @(negedge pi_clk);
        chk_all_zero("reset_init");
        rst = 1'b0;
        @(negedge pi_clk);
        chk_all_zero("idle_after_reset");

        // Run A: ramp pattern, pi_ack held high in IDLE must block the start.
        build_exp();
        read_req = 1'b1;
        pi_ack   = 1'b1;
        repeat (4) @(negedge pi_clk);
        chk("start_blocked", 32'({busy, gpio_oe}), 32'd0);
        pi_ack = 1'b0;
        for (int k = 0; k < NB; k++) xfer(k, (k == 3) ? 5 : 0, 0);
        chk_done("done_a");
        repeat (3) @(negedge pi_clk);
        chk("done_held", 32'({done, busy}), 32'b10);
        read_req = 1'b0;
        @(negedge pi_clk);
        chk("done_clear", 32'(done), 32'd0);

        // Run B: random image, abort after byte 10, then restart.
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);
        build_exp();
        read_req = 1'b1;
        for (int k = 0; k <= 10; k++) xfer(k, $urandom_range(0, 3), $urandom_range(0, 2));
        wait_valid(n);
        chk("abort_wait", 32'(n), 32'd3);
        read_req = 1'b0;
        @(negedge pi_clk);
        chk("abort", 32'({tx_valid, gpio_oe, busy}), 32'd0);
        read_req = 1'b1;
        for (int k = 0; k <= 5; k++) xfer(k, $urandom_range(0, 3), $urandom_range(0, 2));

        // Asynchronous reset while a byte is presented.
        wait_valid(n);
        chk("pre_rst_valid", 32'(tx_valid), 32'd1);
        #2 rst = 1'b1;
        #1 chk_all_zero("reset_async");
        @(negedge pi_clk);
        rst = 1'b0;
        for (int k = 0; k < NB; k++) xfer(k, $urandom_range(0, 3), $urandom_range(0, 2));
        chk_done("done_b");
        read_req = 1'b0;
        @(negedge pi_clk);
        chk("done_clear_b", 32'({done, busy, gpio_oe}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
